// File: rtl/hazard_stall_unit.sv
// Hazard/stall unit for a classic 5-stage pipeline.
// Detects load-use hazards between the ID-stage instruction and the load
// sitting in EX, inserts exactly one bubble per hazard, and freezes the
// whole pipeline while data memory is busy. A memory wait that runs past
// 255 cycles parks the block in a sticky TIMEOUT state until reset.
module hazard_stall_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    input  logic        rs1_use_i,
    input  logic        rs2_use_i,
    input  logic [4:0]  Rd_addr_i,
    input  logic        MemRead_i,
    input  logic        flush_i,
    input  logic        mem_stall_i,
    output logic        stall_o,
    output logic        PCWrite_o,
    output logic        IF_IDWrite_o,
    output logic        pipe_hold_o,
    output logic [4:0]  ex_Rd_o,
    output logic        ex_MemRead_o,
    output logic [15:0] stall_cnt_o,
    output logic        mem_timeout_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_t;

    localparam logic [7:0]  WAIT_LIMIT = 8'd255;
    localparam logic [15:0] CNT_MAX    = 16'hFFFF;

    state_t      r_state;
    state_t      w_nextState;
    logic [7:0]  r_waitCnt;
    logic [7:0]  w_nextWaitCnt;
    logic [4:0]  r_exRd;
    logic        r_exMemRead;
    logic [15:0] r_stallCnt;

    logic        w_rs1Match;
    logic        w_rs2Match;
    logic        w_hz;
    logic        w_stallFsm;
    logic        w_holdFsm;
    logic        w_pcWriteFsm;
    logic        w_stall;
    logic        w_hold;
    logic        w_pcWrite;
    logic        w_bubble;

    // Load-use hazard: the EX-stage load writes a register the ID instruction reads (never x0).
    always_comb begin
        w_rs1Match = rs1_use_i & (rs1_addr_i == r_exRd);
        w_rs2Match = rs2_use_i & (rs2_addr_i == r_exRd);
        w_hz       = valid_i & r_exMemRead & (r_exRd != 5'd0) & (w_rs1Match | w_rs2Match);
    end

    // Next-state, wait-counter and per-state pipeline controls.
    always_comb begin
        w_nextState   = r_state;
        w_nextWaitCnt = r_waitCnt;
        w_stallFsm    = 1'b0;
        w_holdFsm     = 1'b0;
        w_pcWriteFsm  = 1'b1;
        case (r_state)
            RUN: begin
                w_stallFsm   = w_hz & ~flush_i & ~mem_stall_i;
                w_holdFsm    = mem_stall_i;
                w_pcWriteFsm = ~(w_stallFsm | mem_stall_i);
                if (mem_stall_i) begin
                    w_nextState   = MEM_WAIT;
                    w_nextWaitCnt = 8'd1;
                end
            end
            MEM_WAIT: begin
                w_holdFsm    = 1'b1;
                w_pcWriteFsm = 1'b0;
                if (!mem_stall_i) begin
                    w_nextState   = RUN;
                    w_nextWaitCnt = 8'd0;
                end else if (r_waitCnt == WAIT_LIMIT) begin
                    w_nextState = TIMEOUT;
                end else begin
                    w_nextWaitCnt = r_waitCnt + 8'd1;
                end
            end
            TIMEOUT: begin
                w_holdFsm    = 1'b1;
                w_pcWriteFsm = 1'b0;
            end
            default: begin
                w_nextState   = RUN;
                w_nextWaitCnt = 8'd0;
            end
        endcase
    end

    // While reset is asserted the pipeline must run freely regardless of the inputs.
    always_comb begin
        w_stall   = rst_i & w_stallFsm;
        w_hold    = rst_i & w_holdFsm;
        w_pcWrite = ~rst_i | w_pcWriteFsm;
        w_bubble  = w_stall | flush_i | ~valid_i;
    end

    // State register and memory-wait counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= RUN;
            r_waitCnt <= 8'd0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextWaitCnt;
        end
    end

    // EX-stage shadow: frozen during a hold, otherwise takes the ID instruction or a bubble.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_exRd      <= 5'd0;
            r_exMemRead <= 1'b0;
        end else if (!w_hold) begin
            if (w_bubble) begin
                r_exRd      <= 5'd0;
                r_exMemRead <= 1'b0;
            end else begin
                r_exRd      <= Rd_addr_i;
                r_exMemRead <= MemRead_i;
            end
        end
    end

    // Saturating count of inserted bubble cycles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stallCnt <= 16'd0;
        end else if (w_stall && (r_stallCnt != CNT_MAX)) begin
            r_stallCnt <= r_stallCnt + 16'd1;
        end
    end

    assign stall_o       = w_stall;
    assign pipe_hold_o   = w_hold;
    assign PCWrite_o     = w_pcWrite;
    assign IF_IDWrite_o  = w_pcWrite;
    assign ex_Rd_o       = r_exRd;
    assign ex_MemRead_o  = r_exMemRead;
    assign stall_cnt_o   = r_stallCnt;
    assign mem_timeout_o = (r_state == TIMEOUT);

endmodule
